// File: rtl/lv_pwm_burst_decode.sv
// LV-side PWM INTB decoder: synchronises and deglitches the active-low PWM line,
// counts low pulses per burst and reports the burst length as a code / INTB level.
module lv_pwm_burst_decode #(
  parameter int unsigned  FILT_CYC  = 2,
  parameter int unsigned  GAP_W     = 4,
  parameter int unsigned  MAX_PULSE = 7,
  parameter int unsigned  SET_CODE  = 1,
  parameter int unsigned  CLR_CODE  = 3,
  localparam int unsigned CODE_W    = $clog2(MAX_PULSE + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_pwm_n,
  input  logic [GAP_W-1:0]  i_gap_th,
  output logic              o_pwm_gwave,
  output logic              o_flt_pwm_n,
  output logic              o_code_vld,
  output logic [CODE_W-1:0] o_code,
  output logic              o_code_err,
  output logic              o_intb_n,
  output logic              o_busy
);

  localparam int unsigned FCNT_W = $clog2(FILT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OVF   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                sync1, sync2, flt, ev;
  logic [FCNT_W-1:0]   fcnt;
  logic [GAP_W-1:0]    gap_cnt, gap_thr;
  logic [CODE_W-1:0]   pcnt, pcnt_nxt, code_nxt;
  logic                flt_fire, gap_end;
  logic                vld_nxt, err_nxt, intb_nxt;

  assign o_pwm_gwave = i_pwm_n;
  assign o_flt_pwm_n = flt;

  // A zero threshold would end a burst immediately; treat it as one cycle.
  assign gap_thr  = (i_gap_th == '0) ? GAP_W'(1) : i_gap_th;
  assign flt_fire = (sync2 != flt) && (fcnt == FCNT_W'(FILT_CYC - 1));
  assign gap_end  = (state != IDLE) && !ev && (gap_cnt >= gap_thr);

  // Synchroniser, deglitch filter, falling-edge event and gap counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      flt     <= 1'b1;
      fcnt    <= '0;
      ev      <= 1'b0;
      gap_cnt <= '0;
    end else begin
      sync1 <= i_pwm_n;
      sync2 <= sync1;
      if (sync2 == flt) begin
        fcnt <= '0;
      end else if (flt_fire) begin
        fcnt <= '0;
        flt  <= sync2;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
      ev <= flt_fire && flt;
      if (ev || !i_en) begin
        gap_cnt <= '0;
      end else if (gap_cnt != '1) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // FSM state and registered burst outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      o_code_vld <= 1'b0;
      o_code_err <= 1'b0;
      o_code     <= '0;
      o_intb_n   <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      o_code_vld <= vld_nxt;
      o_code_err <= err_nxt;
      o_code     <= code_nxt;
      o_intb_n   <= intb_nxt;
      o_busy     <= (state_nxt != IDLE);
    end
  end

  // Next-state and burst-end decode; a simultaneous event always wins over gap_end.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = o_code;
    intb_nxt  = o_intb_n;
    if (!i_en) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev) begin
            state_nxt = COUNT;
            pcnt_nxt  = CODE_W'(1);
          end
        end
        COUNT: begin
          if (ev) begin
            if (pcnt == CODE_W'(MAX_PULSE)) begin
              state_nxt = OVF;
            end else begin
              pcnt_nxt = pcnt + CODE_W'(1);
            end
          end else if (gap_end) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            vld_nxt   = 1'b1;
            code_nxt  = pcnt;
            if (pcnt == CODE_W'(SET_CODE)) begin
              intb_nxt = 1'b0;
            end else if (pcnt == CODE_W'(CLR_CODE)) begin
              intb_nxt = 1'b1;
            end
          end
        end
        OVF: begin
          if (gap_end) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            err_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          pcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_pwm_burst_decode.sv
// Bench for lv_pwm_burst_decode: burst table, hand-written corner sequences and
// random stimulus, all checked every cycle against a pulse-counting reference model.
module tb_lv_pwm_burst_decode;

  localparam int FILT = 2;
  localparam int MAXP = 7;
  localparam int SETC = 1;
  localparam int CLRC = 3;
  localparam int NVEC = 10;

  logic       clk = 1'b0;
  logic       rst, en, pwm_n;
  logic [3:0] gap_th;
  logic       o_pwm_gwave, o_flt_pwm_n, o_code_vld, o_code_err, o_intb_n, o_busy;
  logic [2:0] o_code;

  int checks   = 0;
  int failures = 0;
  int vld_seen = 0;
  int err_seen = 0;
  bit busy_seen = 0;
  bit flt_low_seen = 0;

  lv_pwm_burst_decode #(
    .FILT_CYC(FILT), .GAP_W(4), .MAX_PULSE(MAXP), .SET_CODE(SETC), .CLR_CODE(CLRC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_pwm_n(pwm_n), .i_gap_th(gap_th),
    .o_pwm_gwave(o_pwm_gwave), .o_flt_pwm_n(o_flt_pwm_n), .o_code_vld(o_code_vld),
    .o_code(o_code), .o_code_err(o_code_err), .o_intb_n(o_intb_n), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: sync delay line, filter as "last FILT synced samples all
  // disagree with the level", burst as an unbounded pulse count judged at the end.
  bit m_s1 = 1, m_s2 = 1, m_flt = 1, m_ev = 0, m_busy = 0;
  bit m_vld = 0, m_err = 0, m_intb = 1;
  int m_pulses = 0, m_last_ev = 0, cyc = 0;
  logic [2:0] m_code = '0;
  bit shist[$];

  task automatic model_step();
    int thr, gap, sz;
    bit tog;
    cyc++;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_flt = 1; m_ev = 0; m_busy = 0; m_pulses = 0;
      m_vld = 0; m_err = 0; m_intb = 1; m_code = '0;
      shist.delete();
      return;
    end
    thr = (gap_th == 0) ? 1 : int'(gap_th);
    gap = cyc - m_last_ev - 1;
    m_vld = 0;
    m_err = 0;
    if (!en) begin
      m_busy = 0;
      m_pulses = 0;
    end else if (m_ev) begin
      m_pulses = m_busy ? m_pulses + 1 : 1;
      m_busy = 1;
    end else if (m_busy && gap >= thr) begin
      m_busy = 0;
      if (m_pulses <= MAXP) begin
        m_vld = 1;
        m_code = 3'(m_pulses);
        if (m_pulses == SETC) m_intb = 0;
        else if (m_pulses == CLRC) m_intb = 1;
      end else begin
        m_err = 1;
      end
    end
    if (m_ev) m_last_ev = cyc;
    shist.push_back(m_s2);
    m_s2 = m_s1;
    m_s1 = pwm_n;
    sz = shist.size();
    tog = (sz >= FILT);
    if (tog) for (int k = sz - FILT; k < sz; k++) if (shist[k] == m_flt) tog = 0;
    m_ev = tog && m_flt;
    if (tog) begin
      m_flt = !m_flt;
      shist.delete();
    end
    if (shist.size() > FILT) void'(shist.pop_front());
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("gwave", 32'(o_pwm_gwave), 32'(pwm_n));
    check("flt",   32'(o_flt_pwm_n), 32'(m_flt));
    check("busy",  32'(o_busy),      32'(m_busy));
    check("vld",   32'(o_code_vld),  32'(m_vld));
    check("err",   32'(o_code_err),  32'(m_err));
    check("code",  32'(o_code),      32'(m_code));
    check("intb",  32'(o_intb_n),    32'(m_intb));
    if (o_code_vld === 1'b1) vld_seen++;
    if (o_code_err === 1'b1) err_seen++;
    if (o_busy === 1'b1) busy_seen = 1;
    if (o_flt_pwm_n === 1'b0) flt_low_seen = 1;
  end

  typedef struct {
    int unsigned th;
    int unsigned npulse;
    int unsigned lo;
    int unsigned hi;
    int          exp_vld;
    int          exp_err;
    logic [2:0]  exp_code;
    logic        exp_intb;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic idle(int n);
    pwm_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic burst(int n, int lo, int hi);
    for (int p = 0; p < n; p++) begin
      pwm_n = 1'b0;
      repeat (lo) @(negedge clk);
      pwm_n = 1'b1;
      repeat (hi) @(negedge clk);
    end
  endtask

  initial begin
    int v0, e0;
    vecs[0] = '{8, 1, 4, 4, 1, 0, 3'd1, 1'b0};
    vecs[1] = '{8, 3, 4, 4, 1, 0, 3'd3, 1'b1};
    vecs[2] = '{8, 2, 4, 4, 1, 0, 3'd2, 1'b1};
    vecs[3] = '{8, 1, 4, 4, 1, 0, 3'd1, 1'b0};
    vecs[4] = '{8, 5, 4, 4, 1, 0, 3'd5, 1'b0};
    vecs[5] = '{8, 8, 4, 4, 0, 1, 3'd5, 1'b0};
    vecs[6] = '{8, 7, 4, 4, 1, 0, 3'd7, 1'b0};
    vecs[7] = '{3, 3, 3, 3, 3, 0, 3'd1, 1'b0};
    vecs[8] = '{0, 2, 2, 4, 2, 0, 3'd1, 1'b0};
    vecs[9] = '{8, 3, 4, 4, 1, 0, 3'd3, 1'b1};

    rst = 1'b1; en = 1'b1; pwm_n = 1'b1; gap_th = 4'd8;
    repeat (3) @(negedge clk);
    check("rst_intb", 32'(o_intb_n), 32'd1);
    check("rst_code", 32'(o_code), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_flt",  32'(o_flt_pwm_n), 32'd1);
    check("rst_vld",  32'(o_code_vld), 32'd0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < NVEC; i++) begin
      gap_th = 4'(vecs[i].th);
      v0 = vld_seen;
      e0 = err_seen;
      burst(int'(vecs[i].npulse), int'(vecs[i].lo), int'(vecs[i].hi));
      idle(30);
      check($sformatf("vec%0d_vld_cnt", i), 32'(vld_seen - v0), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_err_cnt", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_code", i), 32'(o_code), 32'(vecs[i].exp_code));
      check($sformatf("vec%0d_intb", i), 32'(o_intb_n), 32'(vecs[i].exp_intb));
    end

    // Short glitches must never reach the filtered level.
    gap_th = 4'd8;
    busy_seen = 0; flt_low_seen = 0; v0 = vld_seen; e0 = err_seen;
    repeat (6) begin
      pwm_n = 1'b0;
      @(negedge clk);
      idle(3);
    end
    idle(10);
    check("glitch_flt_low", 32'(flt_low_seen), 32'd0);
    check("glitch_busy", 32'(busy_seen), 32'd0);
    check("glitch_pulses", 32'((vld_seen - v0) + (err_seen - e0)), 32'd0);

    // Enable dropped mid-burst discards the partial burst.
    v0 = vld_seen; e0 = err_seen;
    burst(2, 4, 4);
    check("en_busy_mid", 32'(o_busy), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("en_busy_off", 32'(o_busy), 32'd0);
    idle(3);
    en = 1'b1;
    idle(30);
    check("en_no_pulse", 32'((vld_seen - v0) + (err_seen - e0)), 32'd0);
    burst(1, 4, 4);
    idle(30);
    check("en_new_vld", 32'(vld_seen - v0), 32'd1);
    check("en_new_code", 32'(o_code), 32'd1);
    check("en_new_intb", 32'(o_intb_n), 32'd0);

    // Reset mid-burst returns everything to reset values.
    v0 = vld_seen; e0 = err_seen;
    burst(2, 4, 4);
    check("rst_busy_mid", 32'(o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_busy", 32'(o_busy), 32'd0);
    check("rstm_intb", 32'(o_intb_n), 32'd1);
    check("rstm_code", 32'(o_code), 32'd0);
    rst = 1'b0;
    idle(30);
    check("rstm_no_pulse", 32'((vld_seen - v0) + (err_seen - e0)), 32'd0);
    burst(1, 4, 4);
    idle(30);
    check("rstm_new_code", 32'(o_code), 32'd1);
    check("rstm_new_intb", 32'(o_intb_n), 32'd0);

    // Random traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 7) == 0) gap_th = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        en = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      burst(1, int'($urandom_range(1, 6)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(10, 25)));
    end
    en = 1'b1;
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
